// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage pipelined bitwise logic unit with an accumulator.
// S1 registers the request. S2 registers the result and its flags.
// The accumulator is written only when an operation moves from S1 to S2.
// That keeps accumulator updates in program order, once per operation,
// even while the output is stalled.

module logic_unit_pipe #(
    parameter int WIDTH = 16,
    parameter int FUN_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [FUN_W-1:0] ALU_FUN,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Logic_OUT,
    output logic             Logic_flag,
    input  logic             out_ready,
    output logic             Logic_zero,
    output logic             Logic_err
);

    localparam logic [3:0] OP_AND      = 4'b0100;
    localparam logic [3:0] OP_OR       = 4'b0101;
    localparam logic [3:0] OP_NAND     = 4'b0110;
    localparam logic [3:0] OP_NOR      = 4'b0111;
    localparam logic [3:0] OP_XOR      = 4'b1000;
    localparam logic [3:0] OP_XNOR     = 4'b1001;
    localparam logic [3:0] OP_ACC_AND  = 4'b1010;
    localparam logic [3:0] OP_ACC_OR   = 4'b1011;
    localparam logic [3:0] OP_ACC_XOR  = 4'b1100;
    localparam logic [3:0] OP_ACC_LOAD = 4'b1101;
    localparam logic [3:0] OP_ACC_READ = 4'b1110;

    // S1 request register
    logic [WIDTH-1:0] s1_a_reg;
    logic [WIDTH-1:0] s1_b_reg;
    logic [FUN_W-1:0] s1_fun_reg;
    logic             s1_valid_reg;

    // S2 output register and accumulator
    logic [WIDTH-1:0] out_reg;
    logic             flag_reg;
    logic             zero_reg;
    logic             err_reg;
    logic [WIDTH-1:0] acc_reg;

    // Datapath values computed from S1
    logic [WIDTH-1:0] result_next;
    logic             err_next;
    logic [WIDTH-1:0] acc_next;
    logic             acc_we;
    logic             upper_ok;
    logic [3:0]       op;

    logic adv;
    logic accept;

    // S2 can take new data when it is empty or its result is leaving.
    assign adv      = !flag_reg || out_ready;
    assign in_ready = !s1_valid_reg || adv;
    assign accept   = in_valid && in_ready;

    assign op = s1_fun_reg[3:0];

    // Opcode bits above the low four must be zero for a legal opcode.
    generate
        if (FUN_W > 4) begin : g_upper
            assign upper_ok = ~|s1_fun_reg[FUN_W-1:4];
        end else begin : g_no_upper
            assign upper_ok = 1'b1;
        end
    endgenerate

    // Decode the S1 opcode into a result, an error flag and an accumulator update.
    always_comb begin
        result_next = '0;
        err_next    = 1'b0;
        acc_next    = acc_reg;
        acc_we      = 1'b0;
        if (!upper_ok) begin
            err_next = 1'b1;
        end else begin
            case (op)
                OP_AND:      result_next = s1_a_reg & s1_b_reg;
                OP_OR:       result_next = s1_a_reg | s1_b_reg;
                OP_NAND:     result_next = ~(s1_a_reg & s1_b_reg);
                OP_NOR:      result_next = ~(s1_a_reg | s1_b_reg);
                OP_XOR:      result_next = s1_a_reg ^ s1_b_reg;
                OP_XNOR:     result_next = ~(s1_a_reg ^ s1_b_reg);
                OP_ACC_AND: begin
                    acc_next    = acc_reg & s1_a_reg;
                    acc_we      = 1'b1;
                    result_next = acc_next;
                end
                OP_ACC_OR: begin
                    acc_next    = acc_reg | s1_a_reg;
                    acc_we      = 1'b1;
                    result_next = acc_next;
                end
                OP_ACC_XOR: begin
                    acc_next    = acc_reg ^ s1_a_reg;
                    acc_we      = 1'b1;
                    result_next = acc_next;
                end
                OP_ACC_LOAD: begin
                    acc_next    = s1_a_reg;
                    acc_we      = 1'b1;
                    result_next = acc_next;
                end
                OP_ACC_READ: result_next = acc_reg;
                default:     err_next    = 1'b1;
            endcase
        end
    end

    // S1 captures an accepted request and holds it while the pipe is stalled.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_fun_reg   <= '0;
            s1_valid_reg <= 1'b0;
        end else begin
            if (accept) begin
                s1_a_reg   <= A;
                s1_b_reg   <= B;
                s1_fun_reg <= ALU_FUN;
            end
            s1_valid_reg <= accept || (s1_valid_reg && !adv);
        end
    end

    // S2 and the accumulator advance together, so each operation commits exactly once.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out_reg  <= '0;
            flag_reg <= 1'b0;
            zero_reg <= 1'b0;
            err_reg  <= 1'b0;
            acc_reg  <= '0;
        end else if (adv) begin
            if (s1_valid_reg) begin
                out_reg  <= result_next;
                zero_reg <= (result_next == '0);
                err_reg  <= err_next;
                flag_reg <= 1'b1;
                if (acc_we) begin
                    acc_reg <= acc_next;
                end
            end else begin
                flag_reg <= 1'b0;
            end
        end
    end

    assign Logic_OUT  = out_reg;
    assign Logic_flag = flag_reg;
    assign Logic_zero = zero_reg;
    assign Logic_err  = err_reg;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed testbench for logic_unit_pipe at WIDTH=16/FUN_W=4 and WIDTH=32/FUN_W=5.

module tb_logic_unit_pipe;

    logic        clk;
    // 16-bit instance
    logic        rst16;
    logic [15:0] a16, b16;
    logic [3:0]  fun16;
    logic        iv16, ir16, ordy16;
    logic [15:0] out16;
    logic        flag16, zero16, err16;
    // 32-bit instance
    logic        rst32;
    logic [31:0] a32, b32;
    logic [4:0]  fun32;
    logic        iv32, ir32, ordy32;
    logic [31:0] out32;
    logic        flag32, zero32, err32;

    int checks = 0;
    int errors = 0;

    logic [3:0]  f2 [6] = '{4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b0100};
    logic [15:0] e2 [6] = '{16'h0FFF, 16'hFFF0, 16'hF000, 16'h0FF0, 16'hF00F, 16'h000F};
    logic [3:0]  f3 [5] = '{4'b1101, 4'b1100, 4'b1011, 4'b1010, 4'b1110};
    logic [15:0] a3 [5] = '{16'h1234, 16'h1234, 16'h00F0, 16'h0030, 16'h0000};
    logic [15:0] e3 [5] = '{16'h1234, 16'h0000, 16'h00F0, 16'h0030, 16'h0030};

    logic_unit_pipe #(.WIDTH(16), .FUN_W(4)) dut16 (
        .CLK(clk), .RST(rst16), .A(a16), .B(b16), .ALU_FUN(fun16),
        .in_valid(iv16), .in_ready(ir16), .Logic_OUT(out16), .Logic_flag(flag16),
        .out_ready(ordy16), .Logic_zero(zero16), .Logic_err(err16)
    );

    logic_unit_pipe #(.WIDTH(32), .FUN_W(5)) dut32 (
        .CLK(clk), .RST(rst32), .A(a32), .B(b32), .ALU_FUN(fun32),
        .in_valid(iv32), .in_ready(ir32), .Logic_OUT(out32), .Logic_flag(flag32),
        .out_ready(ordy32), .Logic_zero(zero32), .Logic_err(err32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("%s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst16 = 1'b0; a16 = '0; b16 = '0; fun16 = '0; iv16 = 1'b0; ordy16 = 1'b1;
        rst32 = 1'b0; a32 = '0; b32 = '0; fun32 = '0; iv32 = 1'b0; ordy32 = 1'b1;
        repeat (2) tick();
        chk("rst16_out",  32'(out16),  32'h0);
        chk("rst16_flag", 32'(flag16), 32'h0);
        chk("rst16_zero", 32'(zero16), 32'h0);
        chk("rst16_err",  32'(err16),  32'h0);
        chk("rst32_out",  out32,       32'h0);
        chk("rst32_flag", 32'(flag32), 32'h0);
        rst16 = 1'b1; rst32 = 1'b1;
        tick();
        chk("rst16_ready", 32'(ir16), 32'h1);

        // 1: single AND, latency check
        a16 = 16'hF0F0; b16 = 16'hFF00; fun16 = 4'b0100; iv16 = 1'b1;
        $display("t1 issue AND A=%h B=%h", a16, b16);
        tick();
        iv16 = 1'b0;
        chk("t1_flag_early", 32'(flag16), 32'h0);
        tick();
        chk("t1_out",  32'(out16),  32'hF000);
        chk("t1_flag", 32'(flag16), 32'h1);
        chk("t1_zero", 32'(zero16), 32'h0);
        chk("t1_err",  32'(err16),  32'h0);
        tick();
        chk("t1_drain", 32'(flag16), 32'h0);

        // 2: streaming logic ops
        a16 = 16'h00FF; b16 = 16'h0F0F;
        for (int i = 0; i < 6; i++) begin
            fun16 = f2[i]; iv16 = 1'b1;
            $display("t2 issue op=%b A=%h B=%h", fun16, a16, b16);
            chk("t2_ready", 32'(ir16), 32'h1);
            tick();
            if (i > 0) begin
                chk("t2_out",  32'(out16),  32'(e2[i-1]));
                chk("t2_flag", 32'(flag16), 32'h1);
            end
        end
        iv16 = 1'b0;
        tick();
        chk("t2_out_last", 32'(out16), 32'(e2[5]));
        chk("t2_flag_last", 32'(flag16), 32'h1);
        tick();
        chk("t2_drain", 32'(flag16), 32'h0);

        // 3: accumulator chain
        for (int i = 0; i < 5; i++) begin
            fun16 = f3[i]; a16 = a3[i]; iv16 = 1'b1;
            $display("t3 issue op=%b A=%h", fun16, a16);
            tick();
            if (i > 0) begin
                chk("t3_out",  32'(out16),  32'(e3[i-1]));
                chk("t3_zero", 32'(zero16), 32'(e3[i-1] == 16'h0));
            end
        end
        iv16 = 1'b0;
        tick();
        chk("t3_out_last", 32'(out16), 32'(e3[4]));
        chk("t3_err_last", 32'(err16), 32'h0);
        tick();
        chk("t3_drain", 32'(flag16), 32'h0);

        // 4: back-pressure
        ordy16 = 1'b0;
        fun16 = 4'b1101; a16 = 16'h0005; iv16 = 1'b1;
        $display("t4 issue ACC_LOAD A=%h", a16);
        tick();
        fun16 = 4'b1011; a16 = 16'h0030;
        $display("t4 issue ACC_OR A=%h", a16);
        tick();
        chk("t4_first_out",  32'(out16),  32'h0005);
        chk("t4_first_flag", 32'(flag16), 32'h1);
        fun16 = 4'b1100; a16 = 16'h0001;
        $display("t4 issue ACC_XOR A=%h (stalled)", a16);
        chk("t4_ready_low", 32'(ir16), 32'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t4_hold_out",   32'(out16), 32'h0005);
            chk("t4_hold_ready", 32'(ir16),  32'h0);
        end
        ordy16 = 1'b1;
        #1;
        chk("t4_ready_rel", 32'(ir16), 32'h1);
        tick();
        iv16 = 1'b0;
        chk("t4_out2", 32'(out16), 32'h0035);
        tick();
        chk("t4_out3", 32'(out16), 32'h0034);
        tick();
        chk("t4_drain", 32'(flag16), 32'h0);
        fun16 = 4'b1110; iv16 = 1'b1;
        tick();
        iv16 = 1'b0;
        tick();
        chk("t4_acc_read", 32'(out16), 32'h0034);

        // 5: illegal opcodes leave acc alone
        fun16 = 4'b0000; a16 = 16'hFFFF; b16 = 16'hFFFF; iv16 = 1'b1;
        $display("t5 issue op=0000");
        tick();
        fun16 = 4'b1111;
        $display("t5 issue op=1111");
        tick();
        chk("t5_out0", 32'(out16), 32'h0);
        chk("t5_err0", 32'(err16), 32'h1);
        chk("t5_flag0", 32'(flag16), 32'h1);
        fun16 = 4'b1110;
        tick();
        iv16 = 1'b0;
        chk("t5_out15", 32'(out16), 32'h0);
        chk("t5_err15", 32'(err16), 32'h1);
        tick();
        chk("t5_read", 32'(out16), 32'h0034);
        chk("t5_read_err", 32'(err16), 32'h0);
        tick();

        // 6a: reset while full and stalled (16-bit)
        ordy16 = 1'b0;
        fun16 = 4'b1101; a16 = 16'hABCD; iv16 = 1'b1;
        tick();
        fun16 = 4'b0100; a16 = 16'hFFFF; b16 = 16'h1111;
        tick();
        iv16 = 1'b0;
        chk("t6_full_out",   32'(out16), 32'hABCD);
        chk("t6_full_ready", 32'(ir16),  32'h0);
        #2;
        rst16 = 1'b0;
        #1;
        chk("t6_rst_out",   32'(out16),  32'h0);
        chk("t6_rst_flag",  32'(flag16), 32'h0);
        chk("t6_rst_zero",  32'(zero16), 32'h0);
        chk("t6_rst_err",   32'(err16),  32'h0);
        chk("t6_rst_ready", 32'(ir16),   32'h1);
        tick();
        rst16 = 1'b1; ordy16 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_no_stale", 32'(flag16), 32'h0);
        end
        fun16 = 4'b1110; iv16 = 1'b1;
        tick();
        iv16 = 1'b0;
        tick();
        chk("t6_acc_zero", 32'(out16),  32'h0);
        chk("t6_zero_flag", 32'(zero16), 32'h1);

        // 6b: WIDTH=32 with a 5-bit opcode
        a32 = 32'hF0F0F0F0; b32 = 32'hFFFF0000; fun32 = 5'b00100; iv32 = 1'b1;
        $display("t7 issue AND A=%h B=%h", a32, b32);
        tick();
        fun32 = 5'b10100;
        $display("t7 issue op=10100");
        tick();
        iv32 = 1'b0;
        chk("t7_and", out32, 32'hF0F00000);
        chk("t7_and_err", 32'(err32), 32'h0);
        tick();
        chk("t7_upper_out", out32, 32'h0);
        chk("t7_upper_err", 32'(err32), 32'h1);
        tick();
        ordy32 = 1'b0;
        fun32 = 5'b01101; a32 = 32'h12345678; iv32 = 1'b1;
        tick();
        fun32 = 5'b01000; a32 = 32'hFFFFFFFF; b32 = 32'h0;
        tick();
        iv32 = 1'b0;
        chk("t7_full_out", out32, 32'h12345678);
        #2;
        rst32 = 1'b0;
        #1;
        chk("t7_rst_out",  out32,       32'h0);
        chk("t7_rst_flag", 32'(flag32), 32'h0);
        tick();
        rst32 = 1'b1; ordy32 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t7_no_stale", 32'(flag32), 32'h0);
        end
        fun32 = 5'b01110; iv32 = 1'b1;
        tick();
        iv32 = 1'b0;
        tick();
        chk("t7_acc_zero", out32, 32'h0);
        chk("t7_acc_flag", 32'(flag32), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, two-stage pipelined bitwise logic unit with a valid/ready handshake on both sides and an internal accumulator register. It is the configurable successor to the fixed 16-bit ALU logic slice and sits in the ALU datapath next to the arithmetic, shift and compare units. When the downstream sink is ready, it sustains one operation per cycle. Downstream back-pressure stalls the pipeline without dropping or duplicating any operation.

## Interface
- WIDTH, 16, operand, result and accumulator width (≥2)
- FUN_W, 4, opcode width (≥4; only the low 4 bits are decoded, upper bits must be 0, otherwise the opcode is illegal)
- CLK  input  1  clock, all state updates on the rising edge
- RST  input  1  reset, asynchronous, active-low
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- ALU_FUN  input  FUN_W  opcode
- in_valid  input  1  request valid
- in_ready  output  1  unit can accept a request this cycle
- Logic_OUT  output  WIDTH  registered result
- Logic_flag  output  1  result valid (out_valid)
- out_ready  input  1  sink accepts the result this cycle
- Logic_zero  output  1  Logic_OUT == 0 (qualified by Logic_flag)
- Logic_err  output  1  result came from an illegal opcode

## Operation

**Opcodes**
- 0100 AND, 0101 OR, 0110 NAND, 0111 NOR, 1000 XOR, 1001 XNOR; each computes A op B.
- 1010 ACC_AND: acc ← acc & A. 1011 ACC_OR: acc ← acc | A. 1100 ACC_XOR: acc ← acc ^ A.
- 1101 ACC_LOAD: acc ← A. 1110 ACC_READ: acc unchanged.
- For every accumulator opcode (1010–1110), the result is the post-update acc value and B is ignored.
- Any other code is illegal: result is 0, Logic_err = 1, acc unchanged.
- Logic_err = 0 for all legal opcodes.

**Pipeline**
- S1 is a register holding {A, B, ALU_FUN, s1_valid}.
- S2 is the output register holding {Logic_OUT, Logic_zero, Logic_err, Logic_flag}.
- Input handshake: a request is accepted on an edge where in_valid && in_ready. S1 captures the operands on that edge.
- Output handshake: a result is consumed on an edge where Logic_flag && out_ready.
- adv = !Logic_flag || out_ready.
- in_ready = !s1_valid || adv (combinational, does not depend on in_valid).
- On an edge with adv && s1_valid:
  - S2 loads the result computed from S1.
  - acc updates if the S1 opcode is an accumulator opcode.
  - Logic_flag ← 1.
- On an edge with adv && !s1_valid: Logic_flag ← 0. Logic_OUT holds its previous value.
- s1_valid ← accept || (s1_valid && !adv).
- While stalled (!adv), S1, S2 and acc all hold. Accumulator opcodes therefore update acc exactly once, in program order.
- Logic_zero is registered together with Logic_OUT.

## Timing
- Reset (RST low, asynchronous):
  - s1_valid = 0, acc = 0, Logic_OUT = 0, Logic_flag = 0, Logic_zero = 0, Logic_err = 0.
  - in_ready = 1 once reset is released.
- Reset asserted mid-operation discards all in-flight requests. Results from before the reset are never presented afterwards.
- Latency: a request accepted at edge k has Logic_flag = 1 after edge k+1 if S2 is free.
- Throughput: with out_ready held high, one result per cycle and in_ready stays 1.
- Back-pressure:
  - A result stays stable (Logic_OUT/flags held) until it is consumed.
  - At most 2 operations are in flight: one in S1 and one in S2.
  - in_ready = 0 only when S1 and S2 are both full and out_ready = 0.
- Simultaneous accept and advance on the same edge is legal: S2 takes the old S1 contents and S1 takes the new request. No bubble is inserted.
- Back-to-back accumulator operations:
  - Each operation sees the acc value written by its predecessor.
  - acc is written at the S1→S2 transfer, so no hazard exists between them.
- A and B values outside the accept edge are don't-care.

## Test plan
1. Reset, then with out_ready = 1 and WIDTH = 16, issue AND A=F0F0 B=FF00 → Logic_OUT = F000, Logic_flag = 1 one cycle after accept, Logic_zero = 0, Logic_err = 0.
2. Streaming: 6 back-to-back ops (OR, NAND, NOR, XOR, XNOR, AND) with A=00FF, B=0F0F → results 0FFF, FFF0, F000, 0FF0, F00F, 000F on consecutive cycles; in_ready stays 1.
3. Accumulator chain: LOAD A=1234, XOR A=1234, OR A=00F0, AND A=0030, READ → 1234, 0000 (Logic_zero = 1), 00F0, 0030, 0030.
4. Back-pressure:
   - Hold out_ready = 0 after the first result and issue 3 requests. The 3rd sees in_ready = 0 and the first result holds stable.
   - Release out_ready. All results then drain in order, with no loss or duplication, and acc is updated exactly once per accumulator op.
5. Illegal opcode 0000 and 1111 → Logic_OUT = 0, Logic_err = 1, acc unchanged (a following READ returns the prior acc).
6. Assert RST while S1 and S2 are full and stalled → all outputs 0 immediately (asynchronously), acc = 0, and no stale result appears after release; repeat at WIDTH = 32.
